// File: rtl/sound_sdr_arbiter.sv
// Two-port round-robin arbiter sharing one SDRAM read channel between the GA20
// sample cache (port A) and V35 program fetch (port B), with a wait-cycle timeout.
module sound_sdr_arbiter #(
  parameter logic [24:0] A_BASE  = 25'h0,
  parameter logic [24:0] B_BASE  = 25'h0,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic [24:0] a_addr,
  output logic        a_busy,
  output logic        a_rdy,
  output logic [63:0] a_data,
  input  logic        b_req,
  input  logic [24:0] b_addr,
  output logic        b_busy,
  output logic        b_rdy,
  output logic [63:0] b_data,
  output logic        err,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic [63:0] sdr_data,
  input  logic        sdr_rdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic        pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [24:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic        gnt_b_q, gnt_b_d, rr_b_q, rr_b_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [24:0] sdr_addr_q, sdr_addr_d;
  logic [63:0] a_data_q, a_data_d, b_data_q, b_data_d;
  logic        a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic        err_q, err_d;

  logic        done, tmo, fin, start, grant_b;
  logic [24:0] a_sum, b_sum;

  assign done    = (state_q != IDLE) && sdr_rdy;
  assign tmo     = (state_q == WAIT) && !sdr_rdy && (wcnt_q == TIMEOUT);
  assign fin     = done || tmo;
  assign start   = (state_q == IDLE) && (pend_a_q || pend_b_q);
  assign grant_b = (pend_a_q && pend_b_q) ? rr_b_q : pend_b_q;
  assign a_sum   = a_addr + A_BASE;
  assign b_sum   = b_addr + B_BASE;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_a_q || pend_b_q) state_d = ISSUE;
      ISSUE:   state_d = sdr_rdy ? IDLE : WAIT;
      WAIT:    if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdr_req  = (state_q == ISSUE) || (state_q == WAIT);
    sdr_addr = sdr_addr_q;
    a_busy   = pend_a_q;
    b_busy   = pend_b_q;
    a_rdy    = a_rdy_q;
    b_rdy    = b_rdy_q;
    a_data   = a_data_q;
    b_data   = b_data_q;
    err      = err_q;
  end

  always_comb begin
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    gnt_b_d    = gnt_b_q;
    rr_b_d     = rr_b_q;
    sdr_addr_d = sdr_addr_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    wcnt_d     = (state_q == WAIT) ? wcnt_q + 8'd1 : 8'd0;
    a_rdy_d    = fin && !gnt_b_q;
    b_rdy_d    = fin && gnt_b_q;
    err_d      = err_q || tmo;
    if (start) begin
      gnt_b_d    = grant_b;
      rr_b_d     = !grant_b;
      sdr_addr_d = grant_b ? addr_b_q : addr_a_q;
    end
    // A timeout returns all-ones so the client sees an obviously bad word.
    if (fin) begin
      if (gnt_b_q) begin
        b_data_d = done ? sdr_data : '1;
        pend_b_d = 1'b0;
      end else begin
        a_data_d = done ? sdr_data : '1;
        pend_a_d = 1'b0;
      end
    end
    if (a_req && !pend_a_q) begin
      pend_a_d = 1'b1;
      addr_a_d = {a_sum[24:3], 3'b000};
    end
    if (b_req && !pend_b_q) begin
      pend_b_d = 1'b1;
      addr_b_d = {b_sum[24:3], 3'b000};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      gnt_b_q    <= 1'b0;
      rr_b_q     <= 1'b0;
      wcnt_q     <= '0;
      sdr_addr_q <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      a_rdy_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      gnt_b_q    <= gnt_b_d;
      rr_b_q     <= rr_b_d;
      wcnt_q     <= wcnt_d;
      sdr_addr_q <= sdr_addr_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      a_rdy_q    <= a_rdy_d;
      b_rdy_q    <= b_rdy_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_sound_sdr_arbiter.sv
// Directed bench for sound_sdr_arbiter: single access, round-robin, timeout,
// duplicate/back-to-back requests and reset mid-transaction.
module tb_sound_sdr_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [24:0] a_addr = '0, b_addr = '0;
  logic        a_busy, a_rdy, b_busy, b_rdy, err, sdr_req;
  logic [63:0] a_data, b_data;
  logic [24:0] sdr_addr;
  logic [63:0] sdr_data = '0;
  logic        sdr_rdy = 1'b0;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int r0;
  logic sdr_req_prev = 1'b0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  sound_sdr_arbiter #(
    .A_BASE (25'h100000),
    .B_BASE (25'h0),
    .TIMEOUT(8'd4)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .a_req   (a_req),
    .a_addr  (a_addr),
    .a_busy  (a_busy),
    .a_rdy   (a_rdy),
    .a_data  (a_data),
    .b_req   (b_req),
    .b_addr  (b_addr),
    .b_busy  (b_busy),
    .b_rdy   (b_rdy),
    .b_data  (b_data),
    .err     (err),
    .sdr_addr(sdr_addr),
    .sdr_req (sdr_req),
    .sdr_data(sdr_data),
    .sdr_rdy (sdr_rdy)
  );

  always #5 clk_sys = ~clk_sys;

  // Counts SDRAM accesses as rising edges of sdr_req.
  always @(posedge clk_sys) begin
    if (sdr_req && !sdr_req_prev) rises++;
    sdr_req_prev <= sdr_req;
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_sdr_req", sdr_req, 0);
    chk("rst_sdr_addr", sdr_addr, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_b_busy", b_busy, 0);
    chk("rst_a_rdy", a_rdy, 0);
    chk("rst_b_rdy", b_rdy, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    step();

    // Single A request with base offset
    a_req = 1'b1; a_addr = 25'h00013;
    step();
    a_req = 1'b0;
    chk("t1_a_busy_c1", a_busy, 1);
    chk("t1_sdr_req_c1", sdr_req, 0);
    step();
    chk("t1_sdr_req_c2", sdr_req, 1);
    chk("t1_sdr_addr", sdr_addr, 25'h100010);
    step(); step();
    chk("t1_sdr_req_c4", sdr_req, 1);
    step();
    sdr_rdy = 1'b1; sdr_data = 64'h0123456789ABCDEF;
    step();
    sdr_rdy = 1'b0;
    chk("t1_a_rdy", a_rdy, 1);
    chk("t1_a_data", a_data, 64'h0123456789ABCDEF);
    chk("t1_a_busy_low", a_busy, 0);
    chk("t1_sdr_req_low", sdr_req, 0);
    chk("t1_b_rdy", b_rdy, 0);
    step();
    chk("t1_a_rdy_one", a_rdy, 0);
    chk("t1_a_data_hold", a_data, 64'h0123456789ABCDEF);
    chk("t1_b_rdy2", b_rdy, 0);

    // Simultaneous requests after an A grant: pointer now selects B first
    a_req = 1'b1; a_addr = 25'h20; b_req = 1'b1; b_addr = 25'h48;
    step();
    a_req = 1'b0; b_req = 1'b0;
    step();
    chk("t2a_first_addr", sdr_addr, 25'h48);
    sdr_rdy = 1'b1; sdr_data = 64'hB0B0_0000_0000_0001;
    step();
    sdr_rdy = 1'b0;
    chk("t2a_b_rdy", b_rdy, 1);
    chk("t2a_b_data", b_data, 64'hB0B0_0000_0000_0001);
    chk("t2a_a_data_kept", a_data, 64'h0123456789ABCDEF);
    chk("t2a_gap", sdr_req, 0);
    chk("t2a_a_busy", a_busy, 1);
    step();
    chk("t2a_second_req", sdr_req, 1);
    chk("t2a_second_addr", sdr_addr, 25'h100020);
    sdr_rdy = 1'b1; sdr_data = 64'hA0A0_0000_0000_0002;
    step();
    sdr_rdy = 1'b0;
    chk("t2a_a_rdy", a_rdy, 1);
    chk("t2a_a_data", a_data, 64'hA0A0_0000_0000_0002);
    chk("t2a_b_data_kept", b_data, 64'hB0B0_0000_0000_0001);
    chk("t2a_b_rdy_low", b_rdy, 0);

    // Simultaneous requests straight after reset: A first
    do_reset();
    a_req = 1'b1; a_addr = 25'h20; b_req = 1'b1; b_addr = 25'h48;
    step();
    a_req = 1'b0; b_req = 1'b0;
    step();
    chk("t2b_first_addr", sdr_addr, 25'h100020);
    sdr_rdy = 1'b1; sdr_data = 64'h1111_2222_3333_4444;
    step();
    sdr_rdy = 1'b0;
    chk("t2b_a_rdy", a_rdy, 1);
    chk("t2b_gap", sdr_req, 0);
    step();
    chk("t2b_second_addr", sdr_addr, 25'h48);
    sdr_rdy = 1'b1; sdr_data = 64'h5555_6666_7777_8888;
    step();
    sdr_rdy = 1'b0;
    chk("t2b_b_rdy", b_rdy, 1);
    chk("t2b_b_data", b_data, 64'h5555_6666_7777_8888);
    chk("t2b_a_data", a_data, 64'h1111_2222_3333_4444);

    // Timeout on port B with TIMEOUT=4
    b_req = 1'b1; b_addr = 25'h105;
    step();
    b_req = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_sdr_req_%0d", i), sdr_req, 1);
      chk($sformatf("t3_sdr_addr_%0d", i), sdr_addr, 25'h100);
      step();
    end
    chk("t3_b_rdy", b_rdy, 1);
    chk("t3_b_data", b_data, ONES);
    chk("t3_err", err, 1);
    chk("t3_sdr_req_low", sdr_req, 0);
    chk("t3_b_busy_low", b_busy, 0);
    chk("t3_a_data_kept", a_data, 64'h1111_2222_3333_4444);
    step();
    chk("t3_b_rdy_one", b_rdy, 0);
    chk("t3_err_sticky", err, 1);

    // Duplicate A requests while busy: one access
    r0 = rises;
    a_req = 1'b1; a_addr = 25'h8;
    step();
    a_addr = 25'h30;
    step();
    chk("t4_dup_addr", sdr_addr, 25'h100008);
    step();
    a_req = 1'b0;
    sdr_rdy = 1'b1; sdr_data = 64'hDEAD_BEEF_0000_0005;
    step();
    sdr_rdy = 1'b0;
    chk("t4_a_rdy", a_rdy, 1);
    chk("t4_a_data", a_data, 64'hDEAD_BEEF_0000_0005);
    step();
    chk("t4_a_busy_low", a_busy, 0);
    chk("t4_idle", sdr_req, 0);
    step();
    chk("t4_one_access", rises - r0, 1);

    // Back-to-back: new A request in the a_rdy cycle
    r0 = rises;
    a_req = 1'b1; a_addr = 25'h8;
    step();
    a_req = 1'b0;
    step();
    sdr_rdy = 1'b1; sdr_data = 64'h0000_0000_0000_0006;
    step();
    sdr_rdy = 1'b0;
    chk("t4b_a_rdy", a_rdy, 1);
    a_req = 1'b1; a_addr = 25'h40;
    step();
    a_req = 1'b0;
    chk("t4b_busy", a_busy, 1);
    chk("t4b_gap", sdr_req, 0);
    step();
    chk("t4b_req2", sdr_req, 1);
    chk("t4b_addr2", sdr_addr, 25'h100040);
    sdr_rdy = 1'b1; sdr_data = 64'h0000_0000_0000_0007;
    step();
    sdr_rdy = 1'b0;
    chk("t4b_a_rdy2", a_rdy, 1);
    chk("t4b_a_data2", a_data, 64'h0000_0000_0000_0007);
    chk("t4b_two_access", rises - r0, 2);

    // Reset asserted during WAIT, then a stray sdr_rdy
    step();
    a_req = 1'b1; a_addr = 25'h18;
    step();
    a_req = 1'b0;
    step(); step();
    chk("t5_in_wait", sdr_req, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_sdr_req_async", sdr_req, 0);
    chk("t5_a_busy", a_busy, 0);
    chk("t5_b_busy", b_busy, 0);
    chk("t5_a_rdy", a_rdy, 0);
    chk("t5_err_clr", err, 0);
    chk("t5_a_data_clr", a_data, 0);
    step();
    reset_n = 1'b1;
    sdr_rdy = 1'b1; sdr_data = 64'h7777_7777_7777_7777;
    step();
    sdr_rdy = 1'b0;
    chk("t5_no_a_rdy", a_rdy, 0);
    chk("t5_no_b_rdy", b_rdy, 0);
    chk("t5_a_data", a_data, 0);
    chk("t5_sdr_req", sdr_req, 0);
    step();
    chk("t5_sdr_req2", sdr_req, 0);
    chk("t5_a_rdy2", a_rdy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
